pipelined_addsub_nbit: RTL
==========================

// Module: pipelined_addsub_nbit
// PURPOSE
//   Parametrised, pipelined N-bit adder/subtractor; next generation of the team's 4-bit ripple-carry adder.
//   The carry chain is split into CHUNK-bit slices, one register stage per slice, so wide operands close timing.
//   Adds an add/sub mode, a signed-overflow flag and a valid/ready stream interface with backpressure.
//   Sits between operand producers and any stream consumer in the datapath.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK    4  bits resolved per pipeline stage
//   STAGES  WIDTH/CHUNK  localparam, derived; pipeline depth = latency in cycles
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   c_in       in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: add, 1: subtract
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   c_out      out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//   Reset: rst_n low clears all stage valid bits immediately (async).
//     out_valid=0, sum=0, c_out=0, ovf=0.
//     In-flight operations are discarded and never emerge after release.
//   Arithmetic:
//     add: {c_out,sum} = a + b + c_in
//     sub: {c_out,sum} = a + ~b + ~c_in, i.e. a - b - c_in; c_out=0 means borrow
//     ovf = carry into MSB XOR carry out of MSB
//     Results identical for every legal CHUNK.
//   Pipeline:
//     Stage k (0..STAGES-1) adds slice k of a/b' plus the registered carry from stage k-1 (stage 0 uses the mode-adjusted c_in).
//     Upper unprocessed slices of a/b' are skewed forward; completed lower sum slices are delayed, so the full sum aligns at the last stage.
//   Handshake:
//     Transfer in on in_valid & in_ready; out on out_valid & out_ready.
//     en = out_ready | ~out_valid; all stages advance together when en=1, otherwise every stage holds.
//     in_ready = en (combinational).
//     Latency: exactly STAGES cycles from the accepting edge to out_valid, when unstalled.
//     Throughput: 1 op/cycle.
//   Stall: while out_valid & ~out_ready, sum/c_out/ovf/out_valid stay stable; no op is lost or duplicated.
//   Bubbles: in_valid=0 while en=1 inserts a bubble that propagates as out_valid=0 STAGES cycles later.
//   Simultaneous: an input accept and an output pop in the same cycle are legal (full-rate stream).
// TESTING (WIDTH=16, CHUNK=4 unless noted; latency 4)
//   1 Reset: rst_n=0 -> out_valid=0, sum=0, c_out=0, ovf=0.
//     Release, idle 10 cycles -> out_valid stays 0.
//   2 Add:
//     0x0003+0x0004, c_in=0 -> 4 cycles later sum=0x0007, c_out=0, ovf=0.
//     0xFFFF+0x0001 -> 0x0000, c_out=1, ovf=0 (carry crosses all slices).
//     0x7FFF+0x0001 -> 0x8000, ovf=1.
//   3 Sub:
//     0x0005-0x0009 -> 0xFFFC, c_out=0, ovf=0.
//     0x8000-0x0001 -> 0x7FFF, c_out=1, ovf=1.
//     0x0009-0x0002, c_in=1 -> 0x0006.
//   4 Stream: 32 random ops with random in_valid/out_ready.
//     Outputs match the reference model in order; stable while stalled; no loss or duplication.
//   5 Reset mid-operation: assert rst_n with 3 ops in flight -> out_valid=0 at once.
//     After release, only newly issued ops appear.
//   6 WIDTH=4, CHUNK=4 regression (latency 1): 15+15, c_in=1 -> sum=4'hF, c_out=1.
//     10+9 -> 4'h3, c_out=1.
//     3+4 -> 4'h7, c_out=0.

Source files
------------

// File: rtl/pipelined_addsub_nbit.sv
// Pipelined N-bit adder/subtractor, CHUNK bits of carry chain resolved per stage, with signed overflow.
// Latency: STAGES = WIDTH/CHUNK cycles from the accepting edge to out_valid; throughput 1 op/cycle.
// Backpressure: all stages advance together only when out_ready | ~out_valid; otherwise every stage holds.
module pipelined_addsub_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // The whole pipe moves as one: it may advance whenever the output slot is free or being drained.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Subtraction is a + ~b + ~borrow, so the mode only changes the operands fed to stage 0.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? ~c_in : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still waiting to be added, and sum bits resolved once this stage has run.
        localparam int RW = WIDTH - k * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [RW-1:0]  a_in;
        logic [RW-1:0]  b_in;
        logic           cy_in;
        logic           vld_in;
        logic [CHUNK:0] part;
        logic [SW-1:0]  s_nxt;
        logic [SW-1:0]  s_r;
        logic           cy_r;
        logic           vld_r;

        if (k == 0) begin : g_head
            assign a_in   = a;
            assign b_in   = b_eff;
            assign cy_in  = c_eff;
            assign vld_in = in_valid;
            assign s_nxt  = part[CHUNK-1:0];
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_skew.a_r;
            assign b_in   = g_stage[k-1].g_skew.b_r;
            assign cy_in  = g_stage[k-1].cy_r;
            assign vld_in = g_stage[k-1].vld_r;
            // New slice lands above the lower slices that earlier stages already resolved.
            assign s_nxt  = {part[CHUNK-1:0], g_stage[k-1].s_r};
        end

        // Lowest pending slice plus the carry handed over from the previous stage.
        assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_in};

        // Stage register: valid bit, partial sum and carry; cleared asynchronously so nothing in flight survives reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                cy_r  <= 1'b0;
                s_r   <= '0;
            end else if (en) begin
                vld_r <= vld_in;
                cy_r  <= part[CHUNK];
                s_r   <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [RW-CHUNK-1:0] a_r;
            logic [RW-CHUNK-1:0] b_r;

            // Skew the not-yet-added upper slices forward to meet their carry in the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en) begin
                    a_r <= a_in[RW-1:CHUNK];
                    b_r <= b_in[RW-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic ovf_r;

            // Carry into the MSB is a^b^s at that bit; overflow is that carry disagreeing with the carry out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (en) begin
                    ovf_r <= part[CHUNK] ^ part[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_r;
    assign sum       = g_stage[STAGES-1].s_r;
    assign c_out     = g_stage[STAGES-1].cy_r;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;

endmodule
